fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/mips_pkg.sv | 35 +++
 rtl/bht.sv | 39 +++
 rtl/fetch_stage.sv | 102 ++++++++++
 tb/tb_fetch_stage.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: branch opcodes, branch-history counter
// type and its saturating update rule.
package mips_pkg;

    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05;

    typedef logic [1:0] bht_ctr_t;

    // Weakly not-taken: one taken outcome flips the prediction.
    localparam bht_ctr_t CTR_WEAK_NT = 2'b01;

    // Only conditional branches have a meaningful dynamic prediction.
    function automatic logic is_cond_branch(input logic [5:0] opcode);
        logic res;
        case (opcode)
            OP_BEQ:  res = 1'b1;
            OP_BNE:  res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    // Two-bit saturating counter step towards the resolved outcome.
    function automatic bht_ctr_t ctr_update(input bht_ctr_t ctr, input logic taken);
        bht_ctr_t res;
        if (taken) begin
            res = (ctr == 2'b11) ? 2'b11 : ctr + 2'd1;
        end else begin
            res = (ctr == 2'b00) ? 2'b00 : ctr - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/bht.sv
// Branch history table: one 2-bit saturating counter per entry.
// Ports:
//   clk_i, rst_ni        clock, async active-low reset (all counters -> 01)
//   rd_idx_i / rd_ctr_o  combinational lookup; returns the pre-update value
//                        when the same entry is written this cycle
//   wr_idx_i, wr_taken_i, wr_en_i  counter update applied at the clock edge
module bht
    import mips_pkg::*;
#(
    parameter  int ENTRIES = 64,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [IDX_W-1:0] rd_idx_i,
    output bht_ctr_t         rd_ctr_o,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic             wr_taken_i,
    input  logic             wr_en_i
);

    bht_ctr_t ctr_q [ENTRIES];
    bht_ctr_t wr_ctr_d;

    assign wr_ctr_d = ctr_update(ctr_q[wr_idx_i], wr_taken_i);
    assign rd_ctr_o = ctr_q[rd_idx_i];

    // Counter storage: bulk reset to weakly not-taken, single-entry update.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_WEAK_NT;
            end
        end else if (wr_en_i) begin
            ctr_q[wr_idx_i] <= wr_ctr_d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with optional dynamic branch prediction.
// Build option: define FETCH_BHT_EN to include the branch history table;
// otherwise prediction is static not-taken and the BR_* inputs are ignored.
// Ports:
//   CLK, RST_N            clock, async active-low reset (PC -> RESET_PC)
//   STALL                 hold the PC
//   REDIRECT, REDIRECT_PC EX correction; highest priority next-PC source
//   BR_VALID/BR_PC/BR_TAKEN  resolved conditional branch, trains the BHT
//   IM_DATA / IM_ADDR     combinational instruction memory interface
//   PC_OUT, IR_OUT, PREDICT_OUT  to IF/ID
//   FLUSH                 clears IF/ID and ID/EX, mirrors REDIRECT
module fetch_stage
    import mips_pkg::*;
#(
    parameter int          BHT_ENTRIES = 64,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        STALL,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_PC,
    input  logic        BR_VALID,
    input  logic [31:0] BR_PC,
    input  logic        BR_TAKEN,
    input  logic [31:0] IM_DATA,
    output logic [31:0] IM_ADDR,
    output logic [31:0] PC_OUT,
    output logic [31:0] IR_OUT,
    output logic        PREDICT_OUT,
    output logic        FLUSH
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [31:0]      pc_q;
    logic [31:0]      pc_d;
    logic [31:0]      pc_plus4_s;
    logic [31:0]      target_s;
    logic             predict_s;
    logic [IDX_W-1:0] rd_idx_s;

    assign rd_idx_s   = pc_q[IDX_W+1:2];
    assign pc_plus4_s = pc_q + 32'd4;
    // Branch offset is relative to the delay-slot address (PC+4).
    assign target_s   = pc_plus4_s + {{14{IM_DATA[15]}}, IM_DATA[15:0], 2'b00};

`ifdef FETCH_BHT_EN
    bht_ctr_t rd_ctr_s;
    logic     unused_s;

    bht #(
        .ENTRIES (BHT_ENTRIES)
    ) u_bht (
        .clk_i      (CLK),
        .rst_ni     (RST_N),
        .rd_idx_i   (rd_idx_s),
        .rd_ctr_o   (rd_ctr_s),
        .wr_idx_i   (BR_PC[IDX_W+1:2]),
        .wr_taken_i (BR_TAKEN),
        .wr_en_i    (BR_VALID)
    );

    assign predict_s = is_cond_branch(IM_DATA[31:26]) & rd_ctr_s[1];
    assign unused_s  = ^{IM_DATA[25:16], rd_ctr_s[0], BR_PC};
`else
    logic unused_s;

    assign predict_s = 1'b0;
    assign unused_s  = ^{IM_DATA, rd_idx_s, BR_VALID, BR_PC, BR_TAKEN};
`endif

    // Next-PC selection: redirect beats stall beats predicted-taken.
    always_comb begin
        pc_d = pc_plus4_s;
        if (REDIRECT) begin
            pc_d = REDIRECT_PC;
        end else if (STALL) begin
            pc_d = pc_q;
        end else if (predict_s) begin
            pc_d = target_s;
        end else begin
            pc_d = pc_plus4_s;
        end
    end

    // Program counter register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign IM_ADDR     = pc_q;
    assign PC_OUT      = pc_plus4_s;
    assign IR_OUT      = IM_DATA;
    assign PREDICT_OUT = predict_s;
    assign FLUSH       = REDIRECT;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage. Vectors carry hand-computed next
// fetch addresses and predictions; the next-address expectation is queued
// when a vector is driven and compared once the DUT has clocked.
module tb_fetch_stage;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        STALL;
    logic        REDIRECT;
    logic [31:0] REDIRECT_PC;
    logic        BR_VALID;
    logic [31:0] BR_PC;
    logic        BR_TAKEN;
    logic [31:0] IM_DATA;
    logic [31:0] IM_ADDR;
    logic [31:0] PC_OUT;
    logic [31:0] IR_OUT;
    logic        PREDICT_OUT;
    logic        FLUSH;

`ifdef FETCH_BHT_EN
    localparam bit B = 1'b1;
`else
    localparam bit B = 1'b0;
`endif

    localparam logic [31:0] NOP = 32'h0000_0020;

    typedef struct {
        logic        st;
        logic        rd;
        logic [31:0] rpc;
        logic        bv;
        logic [31:0] bpc;
        logic        bt;
        logic [31:0] ir;
        logic [31:0] nxt;
        logic        pred;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    fetch_stage #(
        .BHT_ENTRIES (64),
        .RESET_PC    (32'h0000_0000)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .STALL       (STALL),
        .REDIRECT    (REDIRECT),
        .REDIRECT_PC (REDIRECT_PC),
        .BR_VALID    (BR_VALID),
        .BR_PC       (BR_PC),
        .BR_TAKEN    (BR_TAKEN),
        .IM_DATA     (IM_DATA),
        .IM_ADDR     (IM_ADDR),
        .PC_OUT      (PC_OUT),
        .IR_OUT      (IR_OUT),
        .PREDICT_OUT (PREDICT_OUT),
        .FLUSH       (FLUSH)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] beq(input logic [15:0] imm);
        return {6'h04, 5'd1, 5'd2, imm};
    endfunction

    function automatic logic [31:0] bne(input logic [15:0] imm);
        return {6'h05, 5'd1, 5'd2, imm};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic add(input logic st, input logic rd, input logic [31:0] rpc,
                       input logic bv, input logic [31:0] bpc, input logic bt,
                       input logic [31:0] ir, input logic [31:0] nxt, input logic pred);
        vecs.push_back('{st, rd, rpc, bv, bpc, bt, ir, nxt, pred});
    endtask

    // Called right after a falling edge: drive, check, queue, advance.
    task automatic step(input vec_t v, input int idx);
        logic [31:0] cur;
        STALL       = v.st;
        REDIRECT    = v.rd;
        REDIRECT_PC = v.rpc;
        BR_VALID    = v.bv;
        BR_PC       = v.bpc;
        BR_TAKEN    = v.bt;
        IM_DATA     = v.ir;
        #1;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard_empty at vector %0d", idx);
            cur = IM_ADDR;
        end else begin
            cur = exp_q.pop_front();
            chk($sformatf("im_addr[%0d]", idx), IM_ADDR, cur);
        end
        chk($sformatf("pc_out[%0d]", idx), PC_OUT, cur + 32'd4);
        chk($sformatf("ir_out[%0d]", idx), IR_OUT, v.ir);
        chk($sformatf("flush[%0d]", idx), {31'd0, FLUSH}, {31'd0, v.rd});
        chk($sformatf("predict[%0d]", idx), {31'd0, PREDICT_OUT}, {31'd0, v.pred});
        exp_q.push_back(v.nxt);
        @(negedge CLK);
    endtask

    initial begin
        RST_N = 1'b0; STALL = 1'b0; REDIRECT = 1'b0; REDIRECT_PC = 32'd0;
        BR_VALID = 1'b0; BR_PC = 32'd0; BR_TAKEN = 1'b0; IM_DATA = beq(16'd4);

        // Reset state
        repeat (2) @(negedge CLK);
        #1;
        chk("rst_im_addr", IM_ADDR, 32'h0000_0000);
        chk("rst_pc_out", PC_OUT, 32'h0000_0004);
        chk("rst_flush", {31'd0, FLUSH}, 32'd0);
        chk("rst_predict", {31'd0, PREDICT_OUT}, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        exp_q.push_back(32'h0000_0000);

        //   st    rd    rpc           bv    bpc           bt    ir               next                       pred
        add(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, NOP,             32'h04,                    1'b0);
        add(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, NOP,             32'h08,                    1'b0);
        add(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, bne(16'h0010),   32'h0C,                    1'b0);
        add(1'b0, 1'b1, 32'h20,       1'b0, 32'h0,        1'b0, NOP,             32'h20,                    1'b0);
        // stall three cycles at 0x20, then advance
        add(1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, NOP,             32'h20,                    1'b0);
        add(1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, NOP,             32'h20,                    1'b0);
        add(1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, NOP,             32'h20,                    1'b0);
        add(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, NOP,             32'h24,                    1'b0);
        // train entry for 0x40 taken three times: 01 -> 11
        add(1'b0, 1'b0, 32'h0,        1'b1, 32'h40,       1'b1, NOP,             32'h28,                    1'b0);
        add(1'b0, 1'b0, 32'h0,        1'b1, 32'h40,       1'b1, NOP,             32'h2C,                    1'b0);
        add(1'b0, 1'b0, 32'h0,        1'b1, 32'h40,       1'b1, NOP,             32'h30,                    1'b0);
        add(1'b0, 1'b1, 32'h40,       1'b0, 32'h0,        1'b0, NOP,             32'h40,                    1'b0);
        add(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, beq(16'h0003),   B ? 32'h50 : 32'h44,       B);
        add(1'b0, 1'b1, 32'h40,       1'b0, 32'h0,        1'b0, NOP,             32'h40,                    1'b0);
        // six not-taken updates while stalled on the beq (pre-update value visible)
        add(1'b1, 1'b0, 32'h0,        1'b1, 32'h40,       1'b0, beq(16'h0003),   32'h40,                    B);
        add(1'b1, 1'b0, 32'h0,        1'b1, 32'h40,       1'b0, beq(16'h0003),   32'h40,                    B);
        add(1'b1, 1'b0, 32'h0,        1'b1, 32'h40,       1'b0, beq(16'h0003),   32'h40,                    1'b0);
        add(1'b1, 1'b0, 32'h0,        1'b1, 32'h40,       1'b0, beq(16'h0003),   32'h40,                    1'b0);
        add(1'b1, 1'b0, 32'h0,        1'b1, 32'h40,       1'b0, beq(16'h0003),   32'h40,                    1'b0);
        add(1'b1, 1'b0, 32'h0,        1'b1, 32'h40,       1'b0, beq(16'h0003),   32'h40,                    1'b0);
        // 00 -> 01 -> 10 proves the counter stayed at 00
        add(1'b1, 1'b0, 32'h0,        1'b1, 32'h40,       1'b1, beq(16'h0003),   32'h40,                    1'b0);
        add(1'b1, 1'b0, 32'h0,        1'b1, 32'h40,       1'b1, beq(16'h0003),   32'h40,                    1'b0);
        // negative offset: 0x44 - 8
        add(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, beq(16'hFFFE),   B ? 32'h3C : 32'h44,       B);
        // redirect beats stall
        add(1'b1, 1'b1, 32'h100,      1'b0, 32'h0,        1'b0, NOP,             32'h100,                   1'b0);
        add(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,       1'b0, NOP,             32'hFFFF_FFFC,             1'b0);
        add(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, NOP,             32'h0000_0000,             1'b0);
        add(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, NOP,             32'h04,                    1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i], i);
        end

        // Mid-run asynchronous reset with redirect/stall/update all asserted.
        IM_DATA = beq(16'h0003); REDIRECT = 1'b1; REDIRECT_PC = 32'h200;
        STALL = 1'b1; BR_VALID = 1'b1; BR_PC = 32'h40; BR_TAKEN = 1'b1;
        #2;
        RST_N = 1'b0;
        #1;
        chk("midrst_im_addr", IM_ADDR, 32'h0000_0000);
        chk("midrst_pc_out", PC_OUT, 32'h0000_0004);
        chk("midrst_flush", {31'd0, FLUSH}, 32'd1);
        chk("midrst_predict", {31'd0, PREDICT_OUT}, 32'd0);
        @(posedge CLK);
        #1;
        chk("midrst_hold", IM_ADDR, 32'h0000_0000);
        @(negedge CLK);
        RST_N = 1'b1;
        exp_q.delete();
        exp_q.push_back(32'h0000_0000);

        vecs.delete();
        add(1'b0, 1'b0, 32'h0,  1'b0, 32'h0, 1'b0, beq(16'h0004), 32'h04, 1'b0);
        add(1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, NOP,           32'h40, 1'b0);
        // entry for 0x40 was 10 before reset; must be back at 01
        add(1'b1, 1'b0, 32'h0,  1'b0, 32'h0, 1'b0, beq(16'h0003), 32'h40, 1'b0);
        add(1'b0, 1'b0, 32'h0,  1'b0, 32'h0, 1'b0, NOP,           32'h44, 1'b0);
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i], 100 + i);
        end
        #1;
        chk("final_im_addr", IM_ADDR, exp_q.pop_front());

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
